serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing d = a - b, one bit per clock, LSB first.
- Datapath is a single full-subtractor slice built from two half-subtractor cells, plus a registered borrow.
- It is the inverse counterpart of the team's half-adder/adder blocks: it shares their a/b operand naming and sits beside them as the sequential "undo" path.
- A start/busy/done handshake lets a testbench or controller launch one subtraction and collect the result.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).
- CW, $clog2(WIDTH), width of the internal bit counter (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a subtraction; sampled on rising clk.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when d/bout become valid.
- d  output  WIDTH  difference (a - b) modulo 2^WIDTH.
- bout  output  1  final borrow out: 1 when a < b (unsigned).

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, d=0, bout=0, counter=0, borrow reg=0, shift regs=0. Takes effect immediately, including mid-operation; any partial result is discarded.
- FSM states are IDLE, RUN, DONE.
- IDLE: busy=0. If start=1 at the edge: load sa<=a, sb<=b, borrow<=0, count<=0, go to RUN.
- RUN: busy=1. Each edge processes bit 0 of sa/sb with the current borrow:
  - diff_i = sa[0]^sb[0]^borrow.
  - borrow' = (~sa[0] & sb[0]) | (~(sa[0]^sb[0]) & borrow).
  - diff_i is shifted into the result reg from the MSB side; sa and sb shift right; count increments.
  - When count==WIDTH-1 on an edge: d takes the completed result register, bout<=borrow', go to DONE.
- DONE: busy=0, done=1 for exactly this one cycle. Next edge goes to IDLE. If start=1 on that edge, a new operation is accepted directly (DONE behaves like IDLE for start).
- Latency: done is high during the cycle following the WIDTH-th edge after the start-sampling edge. The start edge is edge 0 and done is visible after edge WIDTH. Back-to-back throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored. a/b may change freely during RUN without effect.
- d and bout hold their last values until the next completion or reset. They change only on the completing edge.
- Arithmetic is unsigned modulo 2^WIDTH; bout equals the borrow out of the MSB.
- WIDTH=2 boundary: RUN lasts exactly 2 cycles; the counter must not overflow for any legal WIDTH.

Decomposition:
- Shared package `arith_pkg`:
  - State enum type for IDLE/RUN/DONE (2 bits).
  - Function `half_sub(x,y)` returning {borrow, diff}, for reuse by combinational blocks.
- One natural sub-module: `half_subtractor` (ports a, b, d, bo; d=a^b, bo=~a&b).
  - Two instances plus an OR gate form the full-subtractor slice used in RUN.
  - It mirrors the team's half-adder cell.

Test Plan:
- WIDTH=8. Reset, then start with a=8'h05, b=8'h03 -> busy high for 8 cycles; done pulses at edge 8; d=8'h02, bout=0.
- a=8'h03, b=8'h05 -> d=8'hFE, bout=1; a=8'h00, b=8'h01 -> d=8'hFF, bout=1 (full borrow ripple).
- a=8'h80, b=8'h01 -> d=8'h7F, bout=0; a=8'hFF, b=8'hFF -> d=8'h00, bout=0; a=b=8'h00 -> d=8'h00, bout=0.
- Start a=8'h10, b=8'h01; at edge 3 pulse start with a=8'h00, b=8'hFF -> ignored; result d=8'h0F, bout=0, exactly one done pulse.
- Hold start=1 continuously with a=8'h0A, b=8'h04 -> results repeat every 9 cycles, each d=8'h06; done never high for 2 consecutive cycles.
- Assert rst asynchronously (mid-cycle) at edge 4 of an operation -> busy, done, d, bout drop to 0 immediately. After release, a new start with a=8'h09, b=8'h02 completes with d=8'h07 at edge 8.

Source files
------------

// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arith_pkg
//  Description : Shared types and helpers for the bit-serial arithmetic
//                blocks. Provides the sequencer state encoding and a
//                combinational half-subtractor helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

    // Sequencer states for the serial arithmetic blocks
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Half subtractor: returns {borrow, diff} for x - y
    function automatic logic [1:0] half_sub(input logic x, input logic y);
        return {~x & y, x ^ y};
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_if
//  Description : Start/busy/done handshake and operand/result bus of the
//                bit-serial subtractor.
//                master : drives start, a, b; observes busy, done, d, bout
//                slave  : the subtractor itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    modport master (
        output start, a, b,
        input  busy, done, d, bout
    );

    modport slave (
        input  start, a, b,
        output busy, done, d, bout
    );
endinterface
`default_nettype wire

// File: rtl/half_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : half_subtractor
//  Description : Single-bit half subtractor, d = a - b.
//                a, b : operand bits
//                d    : difference bit (a ^ b)
//                bo   : borrow out (~a & b)
//  Revision    : 1.0 - initial release
// ============================================================================
module half_subtractor (
    input  wire logic a,
    input  wire logic b,
    output logic      d,
    output logic      bo
);
    assign d  = a ^ b;
    assign bo = ~a & b;
endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial WIDTH-bit subtractor, d = a - b, LSB first, one
//                bit per clock. A start pulse captures a/b; after WIDTH
//                processing cycles the difference and final borrow are
//                published and done pulses for one cycle.
//                clk  : rising-edge clock
//                rst  : asynchronous active-high reset
//                bus  : start/a/b in, busy/done/d/bout out (slave modport)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import arith_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_subtractor_if.slave bus
);
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic             w_finish;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_count;
    logic             r_borrow;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;

    logic             w_d1;
    logic             w_bo1;
    logic             w_diff;
    logic             w_bo2;
    logic             w_borrow_nxt;

    // Full-subtractor slice: two half subtractors plus an OR for the borrow
    half_subtractor u_hs0 (
        .a  (r_sa[0]),
        .b  (r_sb[0]),
        .d  (w_d1),
        .bo (w_bo1)
    );

    half_subtractor u_hs1 (
        .a  (w_d1),
        .b  (r_borrow),
        .d  (w_diff),
        .bo (w_bo2)
    );

    assign w_borrow_nxt = w_bo1 | w_bo2;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control decode; DONE accepts start just like IDLE
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_finish = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = ST_RUN;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_count == c_LAST) begin
                    w_finish = 1'b1;
                    w_next   = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Serial datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_count  <= '0;
            r_borrow <= 1'b0;
            r_d      <= '0;
            r_bout   <= 1'b0;
        end else if (w_load) begin
            r_sa     <= bus.a;
            r_sb     <= bus.b;
            r_borrow <= 1'b0;
            r_count  <= '0;
        end else if (r_state == ST_RUN) begin
            r_sa     <= r_sa >> 1;
            r_sb     <= r_sb >> 1;
            r_res    <= {w_diff, r_res[WIDTH-1:1]};
            r_borrow <= w_borrow_nxt;
            // Counter stops at WIDTH-1, so it never wraps for any legal WIDTH
            if (!w_finish) begin
                r_count <= r_count + 1'b1;
            end
            if (w_finish) begin
                // Publish including the final bit shifted in on this edge
                r_d    <= {w_diff, r_res[WIDTH-1:1]};
                r_bout <= w_borrow_nxt;
            end
        end
    end

    assign bus.busy = (r_state == ST_RUN);
    assign bus.done = (r_state == ST_DONE);
    assign bus.d    = r_d;
    assign bus.bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor (WIDTH=8 and a
//                WIDTH=2 boundary instance). Expected results come from
//                plain unsigned arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    logic [7:0] last_d    = 8'h00;
    logic       last_bout = 1'b0;

    serial_subtractor_if #(.WIDTH(8)) s8 ();
    serial_subtractor_if #(.WIDTH(2)) s2 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (s8.slave)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (s2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation on the WIDTH=8 instance with cycle-accurate checks
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input string tag);
        logic [8:0] r;
        r = {1'b0, av} - {1'b0, bv};
        @(negedge clk);
        s8.start = 1'b1; s8.a = av; s8.b = bv;
        @(posedge clk);
        #1;
        s8.start = 1'b0;
        s8.a = 8'($urandom);
        s8.b = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk({tag, "_busy"}, 32'(s8.busy), 32'd1);
            chk({tag, "_nodone"}, 32'(s8.done), 32'd0);
        end
        chk({tag, "_dhold"}, 32'(s8.d), 32'(last_d));
        chk({tag, "_bhold"}, 32'(s8.bout), 32'(last_bout));
        @(negedge clk);
        chk({tag, "_done"}, 32'(s8.done), 32'd1);
        chk({tag, "_idle"}, 32'(s8.busy), 32'd0);
        chk({tag, "_d"}, 32'(s8.d), 32'(r[7:0]));
        chk({tag, "_bout"}, 32'(s8.bout), 32'(r[8]));
        last_d    = r[7:0];
        last_bout = r[8];
    endtask

    initial begin
        int n_done;
        int last_cyc;
        logic prev_done;
        logic [7:0] got_d;
        logic got_b;

        rst = 1'b1;
        s8.start = 1'b0; s8.a = '0; s8.b = '0;
        s2.start = 1'b0; s2.a = '0; s2.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(s8.busy), 32'd0);
        chk("rst_done", 32'(s8.done), 32'd0);
        chk("rst_d",    32'(s8.d),    32'd0);
        chk("rst_bout", 32'(s8.bout), 32'd0);
        rst = 1'b0;

        // Directed cases
        run_op(8'h05, 8'h03, "t05_03");
        run_op(8'h03, 8'h05, "t03_05");
        run_op(8'h00, 8'h01, "t00_01");
        run_op(8'h80, 8'h01, "t80_01");
        run_op(8'hFF, 8'hFF, "tFF_FF");
        run_op(8'h00, 8'h00, "t00_00");

        // Randomized operands
        for (int i = 0; i < 20; i++) begin
            run_op(8'($urandom), 8'($urandom), "rand");
        end

        // start during RUN is ignored
        @(negedge clk);
        s8.start = 1'b1; s8.a = 8'h10; s8.b = 8'h01;
        @(posedge clk);
        #1 s8.start = 1'b0;
        repeat (3) @(negedge clk);
        s8.start = 1'b1; s8.a = 8'h00; s8.b = 8'hFF;
        @(posedge clk);
        #1 s8.start = 1'b0;
        n_done = 0; got_d = '0; got_b = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (s8.done) begin
                n_done++;
                got_d = s8.d;
                got_b = s8.bout;
            end
        end
        chk("ign_count", 32'(n_done), 32'd1);
        chk("ign_d", 32'(got_d), 32'h0F);
        chk("ign_bout", 32'(got_b), 32'd0);
        last_d = 8'h0F; last_bout = 1'b0;

        // start held high: one result every 9 cycles
        @(negedge clk);
        s8.start = 1'b1; s8.a = 8'h0A; s8.b = 8'h04;
        n_done = 0; last_cyc = -1; prev_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (s8.done) begin
                n_done++;
                chk("bb_d", 32'(s8.d), 32'h06);
                chk("bb_bout", 32'(s8.bout), 32'd0);
                chk("bb_consec", 32'(prev_done), 32'd0);
                if (last_cyc >= 0) chk("bb_gap", 32'(c - last_cyc), 32'd9);
                last_cyc = c;
            end
            prev_done = s8.done;
        end
        chk("bb_count", 32'(n_done), 32'd4);
        s8.start = 1'b0;
        repeat (12) @(negedge clk);
        last_d = 8'h06; last_bout = 1'b0;

        // Asynchronous reset mid-operation
        @(negedge clk);
        s8.start = 1'b1; s8.a = 8'h33; s8.b = 8'h11;
        @(posedge clk);
        #1 s8.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(s8.busy), 32'd0);
        chk("arst_done", 32'(s8.done), 32'd0);
        chk("arst_d",    32'(s8.d),    32'd0);
        chk("arst_bout", 32'(s8.bout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_d = 8'h00; last_bout = 1'b0;
        run_op(8'h09, 8'h02, "post_rst");

        // WIDTH=2 boundary: exhaustive, RUN lasts two cycles
        for (int av = 0; av < 4; av++) begin
            for (int bv = 0; bv < 4; bv++) begin
                @(negedge clk);
                s2.start = 1'b1; s2.a = 2'(av); s2.b = 2'(bv);
                @(posedge clk);
                #1 s2.start = 1'b0;
                @(negedge clk);
                chk("w2_busy0", 32'(s2.busy), 32'd1);
                @(negedge clk);
                chk("w2_busy1", 32'(s2.busy), 32'd1);
                @(negedge clk);
                chk("w2_done", 32'(s2.done), 32'd1);
                chk("w2_d", 32'(s2.d), 32'((av - bv) & 3));
                chk("w2_bout", 32'(s2.bout), 32'(av < bv));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
